parity_tx_scheduler: RTL and testbench



---
 rtl/parity_sched_pkg.sv | 19 +
 rtl/parity_tx_scheduler_rr_arbiter.sv | 42 ++++
 rtl/parity_tx_scheduler.sv | 129 ++++++++++++
 tb/tb_parity_tx_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
// Shared definitions for the parity transmit scheduler.
//   state_e  : scheduler FSM encoding (IDLE / SHIFT / PARITY)
//   ACC_INIT : parity accumulator seed; a seed of 1 yields odd parity
//   id_w()   : width of a requester index (at least 1 bit)
package parity_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_e;

  localparam logic ACC_INIT = 1'b1;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parity_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req    : request vector
//   i_ptr    : index of the highest-priority requester this cycle
//   i_enable : when low, no grant is issued
//   o_gnt    : one-hot grant (zero when nothing is requested or disabled)
//   o_idx    : encoded index of the granted requester
module rr_arbiter
  import parity_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]           i_req,
  input  logic [id_w(NREQ)-1:0]     i_ptr,
  input  logic                      i_enable,
  output logic [NREQ-1:0]           o_gnt,
  output logic [id_w(NREQ)-1:0]     o_idx
);

  localparam int IDW = id_w(NREQ);

  logic w_found;

  // For the active pointer value p, scan p, p+1, ... with wrap and take the
  // first requester found. Every index is a loop constant after unrolling.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int p = 0; p < NREQ; p++) begin
      if (i_ptr == IDW'(p)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (i_enable && !w_found && i_req[(p + k) % NREQ]) begin
            w_found                = 1'b1;
            o_gnt[(p + k) % NREQ]  = 1'b1;
            o_idx                  = IDW'((p + k) % NREQ);
          end
        end
      end
    end
  end

endmodule

// File: rtl/parity_tx_scheduler.sv
// Round-robin scheduler sharing one serial odd-parity transmit path between
// NREQ requesters. A granted W-bit word is sent LSB-first followed by one
// parity beat that makes the total count of ones in the frame odd.
//   clk, reset   : clock and synchronous active-high reset
//   req_valid    : per-requester word available
//   req_data     : requester i word at [i*W +: W]
//   req_ready    : one-hot grant, only while idle
//   ser_bit      : current serial bit
//   ser_valid    : ser_bit is valid
//   ser_last     : current beat is the parity beat
//   ser_ready    : downstream accepts the beat
//   ser_id       : requester owning the current frame
//   busy         : a frame is in progress
//   frames_sent  : completed frames, wrapping
module parity_tx_scheduler
  import parity_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    ser_bit,
  output logic                    ser_valid,
  output logic                    ser_last,
  input  logic                    ser_ready,
  output logic [id_w(NREQ)-1:0]   ser_id,
  output logic                    busy,
  output logic [CNTW-1:0]         frames_sent
);

  localparam int IDW = id_w(NREQ);
  localparam int BCW = id_w(W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_e           r_state;
  logic [W-1:0]     r_shreg;
  logic [BCW-1:0]   r_bitcnt;
  logic             r_acc;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CNTW-1:0]  r_frames;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic [W-1:0]     w_word;
  logic             w_idle;
  logic             w_take;

  assign w_idle = (r_state == IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .i_enable (w_idle),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx)
  );

  // Grants only ever go to valid requesters, so any grant is an accept.
  assign w_take = |w_gnt;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_word = req_data[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_acc    <= ACC_INIT;
      r_ptr    <= '0;
      r_id     <= '0;
      r_frames <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_shreg  <= w_word;
            r_id     <= w_idx;
            r_ptr    <= (w_idx == LAST_ID) ? '0 : w_idx + IDW'(1);
            r_bitcnt <= '0;
            r_acc    <= ACC_INIT;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Parity is folded in one bit at a time as each data beat leaves.
          if (ser_ready) begin
            r_acc    <= r_acc ^ r_shreg[0];
            r_shreg  <= r_shreg >> 1;
            r_bitcnt <= r_bitcnt + BCW'(1);
            if (r_bitcnt == LAST_BIT) r_state <= PARITY;
          end
        end
        PARITY: begin
          if (ser_ready) begin
            r_frames <= r_frames + CNTW'(1);
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ser_valid = (r_state == SHIFT) || (r_state == PARITY);
    ser_last  = (r_state == PARITY);
    ser_bit   = 1'b0;
    if (r_state == SHIFT)  ser_bit = r_shreg[0];
    if (r_state == PARITY) ser_bit = r_acc;
  end

  assign req_ready   = w_gnt;
  assign ser_id      = r_id;
  assign busy        = !w_idle;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_parity_tx_scheduler.sv
// Directed plus randomized bench for parity_tx_scheduler (NREQ=4, W=3,
// CNTW=4 so the frame counter wraps within a short run).
module tb_parity_tx_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int CNTW = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 ser_bit;
  logic                 ser_valid;
  logic                 ser_last;
  logic                 ser_ready;
  logic [IDW-1:0]       ser_id;
  logic                 busy;
  logic [CNTW-1:0]      frames_sent;

  parity_tx_scheduler #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ser_bit     (ser_bit),
    .ser_valid   (ser_valid),
    .ser_last    (ser_last),
    .ser_ready   (ser_ready),
    .ser_id      (ser_id),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int m_ptr  = 0;   // reference round-robin pointer
  int m_frames = 0; // reference completed-frame count

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference arbitration: first valid requester at or after m_ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic eb, input logic el, input int eid);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
    chk({tag, "_bit"},   32'(ser_bit),   32'(eb));
    chk({tag, "_last"},  32'(ser_last),  32'(el));
    chk({tag, "_id"},    32'(ser_id),    32'(eid));
    chk({tag, "_rdy0"},  32'(req_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd1);
  endtask

  // Entered one time unit after a rising edge with the DUT idle. Presents a
  // request set, checks the grant, then follows the whole frame beat by beat.
  // stall_mask[b] holds ser_ready low for three cycles on beat b.
  task automatic do_txn(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] d,
                        input logic [W:0] stall_mask, output int won);
    logic [W-1:0] word;
    logic         eb;
    req_valid = v;
    req_data  = d;
    ser_ready = 1'b1;
    #1;
    won = pick(v);
    chk("idle_busy",  32'(busy),      32'd0);
    chk("idle_valid", 32'(ser_valid), 32'd0);
    chk("grant", 32'(req_ready), (won < 0) ? 32'd0 : (32'd1 << won));
    step();
    if (won < 0) return;
    word  = d[won*W +: W];
    m_ptr = (won + 1) % NREQ;
    for (int b = 0; b <= W; b++) begin
      eb = (b < W) ? word[b] : ~(^word);
      if (stall_mask[b]) begin
        repeat (3) begin
          ser_ready = 1'b0;
          #1;
          check_beat("stall", eb, b == W, won);
          step();
        end
      end
      ser_ready = 1'b1;
      #1;
      check_beat("beat", eb, b == W, won);
      step();
    end
    m_frames = (m_frames + 1) % (1 << CNTW);
    chk("frames_sent", 32'(frames_sent), 32'(m_frames));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int won;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0]   rv;
    logic [NREQ*W-1:0] rd;
    logic [W:0]        rm;

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    ser_ready = 1'b0;
    step();
    step();
    chk("rst_valid",  32'(ser_valid),   32'd0);
    chk("rst_last",   32'(ser_last),    32'd0);
    chk("rst_bit",    32'(ser_bit),     32'd0);
    chk("rst_id",     32'(ser_id),      32'd0);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    chk("rst_ready",  32'(req_ready),   32'd0);
    reset = 1'b0;

    // All-zero word from requester 0: beats 0,0,0 then parity 1.
    do_txn(4'b0001, '0, '0, won);
    chk("t1_winner", 32'(won), 32'd0);

    // Requester 2 twice: 101 (parity 1) then 111 (parity 0), one idle between.
    do_txn(4'b0100, {3'b000, 3'b101, 3'b000, 3'b000}, '0, won);
    chk("t2a_winner", 32'(won), 32'd2);
    do_txn(4'b0100, {3'b000, 3'b111, 3'b000, 3'b000}, '0, won);
    chk("t2b_winner", 32'(won), 32'd2);

    // Stalls on the second data beat and on the parity beat.
    do_txn(4'b0010, {3'b000, 3'b000, 3'b110, 3'b000}, 4'b1010, won);
    chk("stall_winner", 32'(won), 32'd1);

    // Clean reset pulse: pointer and counter return to zero.
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    m_ptr = 0;
    m_frames = 0;
    #1;
    chk("rst2_frames", 32'(frames_sent), 32'd0);
    chk("rst2_busy",   32'(busy),        32'd0);

    // Reset on the second beat of a frame from requester 2.
    req_valid = 4'b0100;
    req_data  = {3'b000, 3'b011, 3'b000, 3'b000};
    ser_ready = 1'b1;
    #1;
    chk("mid_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    reset = 1'b1;
    #1;
    chk("mid_beat1_valid", 32'(ser_valid), 32'd1);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(ser_valid),   32'd0);
    chk("mid_rst_busy",   32'(busy),        32'd0);
    chk("mid_rst_frames", 32'(frames_sent), 32'(m_frames));
    m_ptr = 0;

    // All four requesting: round-robin order 0,1,2,3,0 starting from reset.
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, {3'b011, 3'b110, 3'b001, 3'b100}, '0, won);
      chk("rr_order", 32'(won), 32'(exp_order[i]));
    end

    // Randomized traffic; enough frames to wrap the 4-bit counter.
    for (int i = 0; i < 40; i++) begin
      rv = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rd = (NREQ*W)'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? (W+1)'($urandom) : '0;
      do_txn(rv, rd, rm, won);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
